// File: rtl/flag_branch_unit_if.sv
// EX-stage flag/branch bundle between the pipeline and the flag/branch unit.
// Pipeline side drives requests; the unit returns CCR and redirect state.
interface flag_branch_unit_if #(
    parameter int N     = 16,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             flag_we;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_neg;
    logic             setc;
    logic             clrc;
    logic             br_valid;
    logic [1:0]       br_type;
    logic [N-1:0]     br_target;
    logic             int_save;
    logic             rti_restore;
    logic [2:0]       ccr;
    logic             br_taken;
    logic [N-1:0]     br_pc;
    logic             pipe_flush;
    logic             in_isr;
    logic             err;
    logic [CNT_W-1:0] br_count;

    modport master (
        output stall, flush, flag_we, alu_carry, alu_zero, alu_neg,
        output setc, clrc, br_valid, br_type, br_target,
        output int_save, rti_restore,
        input  ccr, br_taken, br_pc, pipe_flush, in_isr, err, br_count
    );

    modport slave (
        input  stall, flush, flag_we, alu_carry, alu_zero, alu_neg,
        input  setc, clrc, br_valid, br_type, br_target,
        input  int_save, rti_restore,
        output ccr, br_taken, br_pc, pipe_flush, in_isr, err, br_count
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Condition-code register, conditional jump resolve and redirect,
// with a single-level interrupt shadow of the CCR.
module flag_branch_unit #(
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    flag_branch_unit_if.slave bus
);
    typedef enum logic {RUN, ISR} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ccr_q, ccr_d;
    logic [2:0]       shadow_q, shadow_d;
    logic             taken_q, taken_d;
    logic [N-1:0]     pc_q, pc_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic we, bv, sc, cc, cond, taken;

    always_comb begin
        we = bus.flag_we  & ~bus.flush;
        bv = bus.br_valid & ~bus.flush;
        sc = bus.setc     & ~bus.flush;
        cc = bus.clrc     & ~bus.flush;

        cond = 1'b0;
        unique case (bus.br_type)
            2'd0: cond = ccr_q[0];
            2'd1: cond = ccr_q[1];
            2'd2: cond = ccr_q[2];
            2'd3: cond = 1'b1;
        endcase
        taken = bv & cond;

        state_d  = state_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        ccr_d    = ccr_q;

        // Layer updates lowest priority first so later writes win.
        if (we && !bv)
            ccr_d = {bus.alu_carry, bus.alu_neg, bus.alu_zero};
        if (sc ^ cc)
            ccr_d[2] = sc;
        if (taken) begin
            unique case (bus.br_type)
                2'd0: ccr_d[0] = 1'b0;
                2'd1: ccr_d[1] = 1'b0;
                2'd2: ccr_d[2] = 1'b0;
                2'd3: ;
            endcase
        end

        if (bus.int_save && bus.rti_restore) begin
            err_d = 1'b1;
        end else if (bus.int_save) begin
            if (state_q == RUN) begin
                shadow_d = ccr_q;
                state_d  = ISR;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.rti_restore) begin
            if (state_q == ISR) begin
                ccr_d   = shadow_q;
                state_d = RUN;
            end else begin
                err_d = 1'b1;
            end
        end

        if (sc && cc) err_d = 1'b1;
        if (we && bv) err_d = 1'b1;

        taken_d = taken;
        pc_d    = taken ? bus.br_target : pc_q;
        cnt_d   = cnt_q + CNT_W'(taken);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ccr_q    <= '0;
            shadow_q <= '0;
            taken_q  <= 1'b0;
            pc_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (bus.stall) begin
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ccr_q    <= ccr_d;
            shadow_q <= shadow_d;
            taken_q  <= taken_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ccr        = ccr_q;
    assign bus.br_taken   = taken_q;
    assign bus.pipe_flush = taken_q;
    assign bus.br_pc      = pc_q;
    assign bus.in_isr     = (state_q == ISR);
    assign bus.err        = err_q;
    assign bus.br_count   = cnt_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: flags, jumps, ISR shadow,
// errors, stall/flush, counter wrap and async reset.
module tb_flag_branch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    flag_branch_unit_if #(.N(16), .CNT_W(16)) bus ();
    flag_branch_unit #(.N(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic idle();
        bus.stall = 0; bus.flush = 0; bus.flag_we = 0;
        bus.alu_carry = 0; bus.alu_zero = 0; bus.alu_neg = 0;
        bus.setc = 0; bus.clrc = 0; bus.br_valid = 0;
        bus.br_type = 0; bus.br_target = 0;
        bus.int_save = 0; bus.rti_restore = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic alu(input logic c, input logic n, input logic z);
        bus.flag_we = 1; bus.alu_carry = c;
        bus.alu_neg = n; bus.alu_zero = z;
        tick();
    endtask

    task automatic jump(input logic [1:0] t, input logic [15:0] tgt);
        bus.br_valid = 1; bus.br_type = t; bus.br_target = tgt;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #3;
        total++; if (bus.ccr !== 3'b000) $display("FAIL rst_ccr got %b exp 000", bus.ccr); else pass++;
        total++; if (bus.br_taken !== 1'b0) $display("FAIL rst_taken got %b exp 0", bus.br_taken); else pass++;
        total++; if (bus.br_pc !== 16'h0) $display("FAIL rst_pc got %h exp 0000", bus.br_pc); else pass++;
        total++; if (bus.in_isr !== 1'b0) $display("FAIL rst_isr got %b exp 0", bus.in_isr); else pass++;
        total++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.err); else pass++;
        total++; if (bus.br_count !== 16'h0) $display("FAIL rst_cnt got %h exp 0000", bus.br_count); else pass++;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_jz();
        alu(0, 0, 1);
        total++; if (bus.ccr !== 3'b001) $display("FAIL jz_ccr_set got %b exp 001", bus.ccr); else pass++;
        jump(2'd0, 16'h0040);
        total++; if (bus.br_taken !== 1'b1) $display("FAIL jz_taken got %b exp 1", bus.br_taken); else pass++;
        total++; if (bus.pipe_flush !== 1'b1) $display("FAIL jz_flush got %b exp 1", bus.pipe_flush); else pass++;
        total++; if (bus.br_pc !== 16'h0040) $display("FAIL jz_pc got %h exp 0040", bus.br_pc); else pass++;
        total++; if (bus.ccr !== 3'b000) $display("FAIL jz_clr got %b exp 000", bus.ccr); else pass++;
        tick();
        total++; if (bus.br_taken !== 1'b0) $display("FAIL jz_pulse got %b exp 0", bus.br_taken); else pass++;
        total++; if (bus.br_count !== 16'd1) $display("FAIL jz_cnt got %h exp 0001", bus.br_count); else pass++;
    endtask

    task automatic test_not_taken_jmp();
        jump(2'd2, 16'h0999);
        total++; if (bus.br_taken !== 1'b0) $display("FAIL jc_taken got %b exp 0", bus.br_taken); else pass++;
        total++; if (bus.br_pc !== 16'h0040) $display("FAIL jc_pc got %h exp 0040", bus.br_pc); else pass++;
        alu(1, 1, 1);
        jump(2'd3, 16'h1234);
        total++; if (bus.br_taken !== 1'b1) $display("FAIL jmp_taken got %b exp 1", bus.br_taken); else pass++;
        total++; if (bus.br_pc !== 16'h1234) $display("FAIL jmp_pc got %h exp 1234", bus.br_pc); else pass++;
        total++; if (bus.ccr !== 3'b111) $display("FAIL jmp_ccr got %b exp 111", bus.ccr); else pass++;
        jump(2'd1, 16'h0500);
        total++; if (bus.ccr !== 3'b101) $display("FAIL jn_clr got %b exp 101", bus.ccr); else pass++;
        total++; if (bus.br_count !== 16'd3) $display("FAIL jn_cnt got %h exp 0003", bus.br_count); else pass++;
    endtask

    task automatic test_isr();
        do_reset();
        alu(1, 1, 0);
        bus.int_save = 1; tick();
        total++; if (bus.in_isr !== 1'b1) $display("FAIL isr_enter got %b exp 1", bus.in_isr); else pass++;
        alu(0, 0, 0);
        total++; if (bus.ccr !== 3'b000) $display("FAIL isr_alu got %b exp 000", bus.ccr); else pass++;
        bus.rti_restore = 1; tick();
        total++; if (bus.ccr !== 3'b110) $display("FAIL rti_ccr got %b exp 110", bus.ccr); else pass++;
        total++; if (bus.in_isr !== 1'b0) $display("FAIL rti_isr got %b exp 0", bus.in_isr); else pass++;
        total++; if (bus.err !== 1'b0) $display("FAIL isr_err got %b exp 0", bus.err); else pass++;
    endtask

    task automatic test_errors();
        bus.rti_restore = 1; tick();
        total++; if (bus.err !== 1'b1) $display("FAIL rti_run_err got %b exp 1", bus.err); else pass++;
        total++; if (bus.ccr !== 3'b110) $display("FAIL rti_run_ccr got %b exp 110", bus.ccr); else pass++;
        do_reset();
        alu(0, 1, 0);
        bus.int_save = 1; tick();
        alu(0, 0, 1);
        bus.int_save = 1; tick();
        total++; if (bus.err !== 1'b1) $display("FAIL nest_err got %b exp 1", bus.err); else pass++;
        bus.rti_restore = 1; tick();
        total++; if (bus.ccr !== 3'b010) $display("FAIL nest_shadow got %b exp 010", bus.ccr); else pass++;
        do_reset();
        bus.setc = 1; bus.flag_we = 1; bus.alu_neg = 1; bus.alu_zero = 1;
        tick();
        total++; if (bus.ccr !== 3'b111) $display("FAIL setc_we got %b exp 111", bus.ccr); else pass++;
        bus.clrc = 1; tick();
        total++; if (bus.ccr !== 3'b011) $display("FAIL clrc got %b exp 011", bus.ccr); else pass++;
        total++; if (bus.err !== 1'b0) $display("FAIL clrc_err got %b exp 0", bus.err); else pass++;
        bus.setc = 1; bus.clrc = 1; tick();
        total++; if (bus.ccr !== 3'b011) $display("FAIL both_ccr got %b exp 011", bus.ccr); else pass++;
        total++; if (bus.err !== 1'b1) $display("FAIL both_err got %b exp 1", bus.err); else pass++;
        do_reset();
        bus.flag_we = 1; bus.alu_carry = 1;
        bus.br_valid = 1; bus.br_type = 2'd2; tick();
        total++; if (bus.ccr !== 3'b000) $display("FAIL brwe_ccr got %b exp 000", bus.ccr); else pass++;
        total++; if (bus.err !== 1'b1) $display("FAIL brwe_err got %b exp 1", bus.err); else pass++;
    endtask

    task automatic test_stall_flush();
        do_reset();
        bus.stall = 1; bus.br_valid = 1; bus.br_type = 2'd3;
        bus.br_target = 16'h00AA; tick();
        total++; if (bus.br_taken !== 1'b0) $display("FAIL stall_taken got %b exp 0", bus.br_taken); else pass++;
        total++; if (bus.br_pc !== 16'h0) $display("FAIL stall_pc got %h exp 0000", bus.br_pc); else pass++;
        jump(2'd3, 16'h00BB);
        bus.stall = 1; bus.br_valid = 1; bus.br_type = 2'd3; tick();
        total++; if (bus.br_taken !== 1'b0) $display("FAIL stall_pulse got %b exp 0", bus.br_taken); else pass++;
        total++; if (bus.br_count !== 16'd1) $display("FAIL stall_cnt got %h exp 0001", bus.br_count); else pass++;
        bus.flush = 1; bus.br_valid = 1; bus.br_type = 2'd3;
        bus.flag_we = 1; bus.alu_zero = 1; tick();
        total++; if (bus.br_taken !== 1'b0) $display("FAIL flush_taken got %b exp 0", bus.br_taken); else pass++;
        total++; if (bus.ccr !== 3'b000) $display("FAIL flush_ccr got %b exp 000", bus.ccr); else pass++;
        total++; if (bus.err !== 1'b0) $display("FAIL flush_err got %b exp 0", bus.err); else pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.br_valid = 1; bus.br_type = 2'd3; bus.br_target = 16'h0F0F;
        repeat (65535) @(posedge clk);
        #1;
        total++; if (bus.br_count !== 16'hFFFF) $display("FAIL wrap_max got %h exp ffff", bus.br_count); else pass++;
        tick();
        total++; if (bus.br_count !== 16'h0000) $display("FAIL wrap_zero got %h exp 0000", bus.br_count); else pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.int_save = 1; bus.br_valid = 1; bus.br_type = 2'd3;
        bus.br_target = 16'h0777;
        @(posedge clk); #1;
        idle();
        total++; if (bus.br_taken !== 1'b1) $display("FAIL mid_pre got %b exp 1", bus.br_taken); else pass++;
        #2 rst_n = 0;
        #1;
        total++; if (bus.br_taken !== 1'b0) $display("FAIL mid_taken got %b exp 0", bus.br_taken); else pass++;
        total++; if (bus.pipe_flush !== 1'b0) $display("FAIL mid_flush got %b exp 0", bus.pipe_flush); else pass++;
        total++; if (bus.br_pc !== 16'h0) $display("FAIL mid_pc got %h exp 0000", bus.br_pc); else pass++;
        total++; if (bus.in_isr !== 1'b0) $display("FAIL mid_isr got %b exp 0", bus.in_isr); else pass++;
        total++; if (bus.br_count !== 16'h0) $display("FAIL mid_cnt got %h exp 0000", bus.br_count); else pass++;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        idle();
        test_reset();
        test_jz();
        test_not_taken_jmp();
        test_isr();
        test_errors();
        test_stall_flush();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
